// File: rtl/add_serial_sched_pkg.sv
// Shared types and default sizing for the serial-adder scheduler.
package add_sched_pkg;
    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_LAT  = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        GAP     = 3'd4
    } state_t;
endpackage

// File: rtl/add_serial_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick
    import add_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = IW'((32'(ptr) + i) % NREQ);
            if (!any && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one fixed-latency serial adder among NREQ requesters.
module add_serial_sched
    import add_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int LAT  = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              busy,
    output logic              add_en,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_out
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LAT);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            add_en    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            // Pulsed outputs default low so each is high for exactly one cycle.
            gnt       <= '0;
            add_en    <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        winner <= pick_idx;
                        add_a  <= a_in[pick_idx*W +: W];
                        add_b  <= b_in[pick_idx*W +: W];
                        gnt    <= pick_grant;
                        add_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CW'(LAT - 2)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    rsp_data          <= add_out;
                    rsp_valid[winner] <= 1'b1;
                    ptr               <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    state             <= GAP;
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_serial_sched.sv
// Directed self-checking bench for add_serial_sched with a behavioural fixed-latency adder.
module tb_add_serial_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int LAT  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              busy;
    logic              add_en;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_out;

    int compared = 0;
    int failed   = 0;

    add_serial_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out)
    );

    always #5 clk = ~clk;

    // Adder model: junk on add_out until the edge just before the sum is due.
    int unsigned   k;
    logic [W-1:0]  pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= 0;
            pend    <= '0;
            add_out <= '0;
        end else if (add_en) begin
            k       <= 1;
            pend    <= add_a + add_b;
            add_out <= 8'hA5;
        end else if (k != 0) begin
            if (k == LAT - 1) begin
                add_out <= pend;
                k       <= 0;
            end else begin
                k <= k + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle T; leaves the bench in cycle T+12 (IDLE again).
    task automatic do_op(input logic [3:0] set_mask, input logic [3:0] after_mask,
                         input logic [3:0] pulse, input int w, input logic [7:0] sum);
        logic [3:0] oh;
        logic [3:0] rv_acc;
        logic       busy_acc;
        oh       = 4'b0001 << w;
        rv_acc   = '0;
        busy_acc = 1'b1;
        req = set_mask;
        step();
        chk("gnt_launch", 32'(gnt), 32'(oh));
        chk("add_en_launch", 32'(add_en), 1);
        chk("busy_launch", 32'(busy), 1);
        chk("add_a", 32'(add_a), 32'(a_in[w*8 +: 8]));
        chk("add_b", 32'(add_b), 32'(b_in[w*8 +: 8]));
        req = after_mask;
        step();
        chk("add_en_off", 32'(add_en), 0);
        chk("gnt_off", 32'(gnt), 0);
        for (int c = 3; c <= 10; c++) begin
            rv_acc   = rv_acc | rsp_valid | gnt;
            busy_acc = busy_acc & busy;
            step();
            if (c == 5) req = after_mask | pulse;
            if (c == 6) req = after_mask;
        end
        rv_acc = rv_acc | rsp_valid | gnt;
        busy_acc = busy_acc & busy;
        chk("quiet_wait", 32'(rv_acc), 0);
        chk("busy_wait", 32'(busy_acc), 1);
        step();
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_data", 32'(rsp_data), 32'(sum));
        chk("busy_gap", 32'(busy), 1);
        step();
        chk("rsp_clear", 32'(rsp_valid), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("gnt_idle", 32'(gnt), 0);
    endtask

    initial begin
        logic [3:0] acc;
        rst  = 1'b1;
        req  = 4'b1111;
        a_in = {8'h40, 8'h30, 8'h20, 8'h10};
        b_in = {8'h04, 8'h03, 8'h02, 8'h01};
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_add_en", 32'(add_en), 0);
        chk("rst_add_ab", 32'({add_a, add_b}), 0);
        rst = 1'b0;

        // Fairness: all four held from reset, grants rotate 0,1,2,3,0 every 12 cycles.
        do_op(4'b1111, 4'b1111, 4'b0000, 0, 8'h11);
        do_op(4'b1111, 4'b1111, 4'b0000, 1, 8'h22);
        do_op(4'b1111, 4'b1111, 4'b0000, 2, 8'h33);
        do_op(4'b1111, 4'b1111, 4'b0000, 3, 8'h44);
        do_op(4'b1111, 4'b0000, 4'b0000, 0, 8'h11);

        // Single op on requester 2 (pointer 1 -> 3 afterwards).
        a_in[23:16] = 8'h35;
        b_in[23:16] = 8'h4A;
        do_op(4'b0100, 4'b0000, 4'b0000, 2, 8'h7F);

        // Pointer skip: from 3 only req[1] -> 1; then from 2 with {1,0} -> wrap to 0.
        a_in[15:8] = 8'h21;
        b_in[15:8] = 8'h12;
        do_op(4'b0010, 4'b0000, 4'b0000, 1, 8'h33);
        a_in[7:0] = 8'hFF;
        b_in[7:0] = 8'h01;
        do_op(4'b0011, 4'b0000, 4'b0000, 0, 8'h00);

        // Carry out of the top bit is dropped.
        a_in[7:0] = 8'h80;
        b_in[7:0] = 8'h80;
        do_op(4'b0001, 4'b0000, 4'b0000, 0, 8'h00);
        a_in[7:0] = 8'h7F;
        b_in[7:0] = 8'h01;
        do_op(4'b0001, 4'b0000, 4'b0000, 0, 8'h80);

        // req[1] pulses during WAIT and is withdrawn before IDLE.
        a_in[7:0] = 8'h05;
        b_in[7:0] = 8'h06;
        do_op(4'b0001, 4'b0000, 4'b0010, 0, 8'h0B);
        acc = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            acc = acc | gnt | rsp_valid | {3'b000, busy};
        end
        chk("withdrawn_quiet", 32'(acc), 0);

        // Reset in the middle of WAIT; pointer is 1 before reset.
        req = 4'b0100;
        step();
        chk("pre_rst_gnt", 32'(gnt), 32'(4'b0100));
        req = 4'b0000;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        #1;
        chk("midrst_gnt_rsp", 32'({gnt, rsp_valid}), 0);
        chk("midrst_rsp_data", 32'(rsp_data), 0);
        chk("midrst_busy_en", 32'({busy, add_en}), 0);
        chk("midrst_add_ab", 32'({add_a, add_b}), 0);
        step();
        rst = 1'b0;
        acc = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            acc = acc | gnt | rsp_valid;
        end
        chk("lost_op_quiet", 32'(acc), 0);
        a_in[7:0] = 8'h11;
        b_in[7:0] = 8'h22;
        do_op(4'b0011, 4'b0000, 4'b0000, 0, 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
